// File: rtl/register_file_pkg.sv
// Shared types and constants for the register_file array and its helpers.
package register_file_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Every stored bit, and every read register bit, resets to this value.
  localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/register_file_reg_word.sv
// One WIDTH-bit storage word: loads d_i on a clock edge with en_i high.
// Asynchronous active-low reset to the shared reset value.
module reg_word
  import register_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= {WIDTH{RST_BIT}};
    end else if (en_i) begin
      word_q <= d_i;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/register_file.sv
// DEPTH x WIDTH register array: one write port, two 1-cycle registered read ports with
// write-first bypass, and a DEPTH+1 cycle clear-all sequence that blocks writes while busy.
module register_file
  import register_file_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam logic [WIDTH-1:0]  ZERO_WORD = {WIDTH{RST_BIT}};
  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              clr_done_q;

  logic              wr_acc;
  logic              clearing;
  logic [DEPTH-1:0]  word_en;
  logic [WIDTH-1:0]  word_d;
  logic [WIDTH-1:0]  word_q [DEPTH];
  logic [WIDTH-1:0]  rdata0_d;
  logic [WIDTH-1:0]  rdata1_d;

  // Writes and the clear walk never overlap: a write needs busy low, the walk keeps it high.
  assign clearing = (state_q == ST_CLEAR);
  assign wr_acc   = en & we & ~busy_q;
  assign word_d   = clearing ? ZERO_WORD : wdata;

  always_comb begin
    word_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word_en[i] = (wr_acc && (waddr == ADDR_W'(i))) ||
                   (clearing && (cnt_q == ADDR_W'(i)));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (word_en[g]),
      .d_i    (word_d),
      .q_o    (word_q[g])
    );
  end

  // Read data reflects the array contents as they stand after this edge.
  always_comb begin
    rdata0_d = word_q[raddr0];
    if (wr_acc && (raddr0 == waddr)) begin
      rdata0_d = wdata;
    end else if (clearing && (raddr0 == cnt_q)) begin
      rdata0_d = ZERO_WORD;
    end
  end

  always_comb begin
    rdata1_d = word_q[raddr1];
    if (wr_acc && (raddr1 == waddr)) begin
      rdata1_d = wdata;
    end else if (clearing && (raddr1 == cnt_q)) begin
      rdata1_d = ZERO_WORD;
    end
  end

  reg_word #(.WIDTH(WIDTH)) u_rdata0 (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (en),
    .d_i    (rdata0_d),
    .q_o    (rdata0)
  );

  reg_word #(.WIDTH(WIDTH)) u_rdata1 (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (en),
    .d_i    (rdata1_d),
    .q_o    (rdata1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q    <= ST_DONE;
            clr_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file against an array-level reference model.
module tb_register_file;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             clr_req;
  logic             busy;
  logic             clr_done;

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr0   (raddr0),
    .raddr1   (raddr1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: word contents, expected read registers, and the number of
  // edges elapsed since a clear was accepted (0 = no clear running).
  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] rd0_m;
  logic [WIDTH-1:0] rd1_m;
  int               age;
  int               busy_cnt;
  int               done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rd0_m = '0;
    rd1_m = '0;
    age   = 0;
  endtask

  task automatic drive(input int e, input int w, input int wa, input int wd,
                       input int r0, input int r1, input int c);
    en      = 1'(e);
    we      = 1'(w);
    waddr   = AW'(wa);
    wdata   = WIDTH'(wd);
    raddr0  = AW'(r0);
    raddr1  = AW'(r1);
    clr_req = 1'(c);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    if (age >= 1 && age <= DEPTH) mem_m[age-1] = '0;
    if (age == 0 && en && we) mem_m[waddr] = wdata;
    if (en) begin
      rd0_m = mem_m[raddr0];
      rd1_m = mem_m[raddr1];
    end
    if (age == DEPTH + 1) age = 0;
    else if (age > 0)     age++;
    else if (clr_req)     age = 1;
    #1;
    chk("rdata0", 32'(rdata0), 32'(rd0_m));
    chk("rdata1", 32'(rdata1), 32'(rd1_m));
    chk("busy", 32'(busy), 32'(age != 0));
    chk("clr_done", 32'(clr_done), 32'(age == DEPTH + 1));
    if (busy) busy_cnt++;
    if (clr_done) done_cnt++;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    chk("rst_rdata0", 32'(rdata0), 32'h0);
    chk("rst_rdata1", 32'(rdata1), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(clr_done), 32'h0);
    model_reset();
    #1 rst = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 0, i, DEPTH - 1 - i, 0);
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rst      = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset and blank readback
    #1;
    reset_mid();
    read_all();

    // Write then read, then hold with en low
    drive(1, 1, 3, 'hA5, 0, 0, 0);  cycle();
    drive(1, 1, 15, 'h3C, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 3, 15, 0);    cycle();
    chk("wr_rd0", 32'(rdata0), 32'hA5);
    chk("wr_rd1", 32'(rdata1), 32'h3C);
    drive(0, 1, 3, 'hFF, 0, 1, 0);  cycle();
    chk("hold_rd0", 32'(rdata0), 32'hA5);
    chk("hold_rd1", 32'(rdata1), 32'h3C);
    drive(1, 0, 0, 0, 3, 3, 0);     cycle();
    chk("dropped_wr", 32'(rdata0), 32'hA5);

    // Write-first bypass
    drive(1, 1, 7, 'h11, 0, 0, 0);  cycle();
    drive(1, 1, 7, 'h77, 7, 7, 0);  cycle();
    chk("byp_rd0", 32'(rdata0), 32'h77);
    chk("byp_rd1", 32'(rdata1), 32'h77);

    // Clear sequence with blocked writes, a re-request and the clear bypass
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, i, 'hFF, 0, 0, 0);
      cycle();
    end
    busy_cnt = 0;
    done_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 1);
    cycle();
    for (int k = 1; k <= DEPTH + 3; k++) begin
      drive(1, (k <= DEPTH + 1) ? 1 : 0, 0, 'h55, 5, 9, (k == 3) ? 1 : 0);
      cycle();
      if (k == 6) begin
        chk("clr_byp_rd0", 32'(rdata0), 32'h00);
        chk("clr_byp_rd1", 32'(rdata1), 32'hFF);
      end
    end
    chk("clr_busy_len", 32'(busy_cnt), 32'(DEPTH + 1));
    chk("clr_done_cnt", 32'(done_cnt), 32'h1);
    read_all();

    // Reset in the middle of a clear
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, i, $urandom, 0, 0, 0);
      cycle();
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 0, 0, 8, 3, 0);
      cycle();
    end
    reset_mid();
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      drive(1, 0, 0, 0, k % DEPTH, (k + 5) % DEPTH, 0);
      cycle();
    end
    chk("abort_busy", 32'(busy_cnt), 32'h0);
    chk("abort_done", 32'(done_cnt), 32'h0);
    busy_cnt = 0;
    done_cnt = 0;
    drive(1, 0, 0, 0, 0, 0, 1);
    cycle();
    for (int k = 1; k <= DEPTH + 3; k++) begin
      drive(1, 0, 0, 0, k % DEPTH, 0, 0);
      cycle();
    end
    chk("reclr_busy_len", 32'(busy_cnt), 32'(DEPTH + 1));
    chk("reclr_done_cnt", 32'(done_cnt), 32'h1);

    // Randomised traffic
    repeat (2000) begin
      drive(($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 1)),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
            ($urandom_range(0, 39) == 0) ? 1 : 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
